// File: rtl/vga_pkg.sv
// Shared timing constants and RGB565 colours for the 640x480@60 Hz VGA path.
// All timing constants are 10-bit so that compares against the counters stay width-matched.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BACK  = 10'd40;
  localparam logic [9:0] H_LEFT  = 10'd8;
  localparam logic [9:0] H_VALID = 10'd640;
  localparam logic [9:0] H_RIGHT = 10'd8;
  localparam logic [9:0] H_FRONT = 10'd8;
  localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;

  // Vertical timing, in lines
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BACK   = 10'd25;
  localparam logic [9:0] V_TOP    = 10'd8;
  localparam logic [9:0] V_VALID  = 10'd480;
  localparam logic [9:0] V_BOTTOM = 10'd8;
  localparam logic [9:0] V_FRONT  = 10'd2;
  localparam logic [9:0] V_TOTAL  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;

  // First active column / row
  localparam logic [9:0] HA = H_SYNC + H_BACK + H_LEFT;
  localparam logic [9:0] VA = V_SYNC + V_BACK + V_TOP;

  // Coordinate value presented when no pixel is being requested
  localparam logic [9:0] PIX_IDLE = 10'h3FF;

  // RGB565 colours shared with the pixel generator
  typedef logic [15:0] rgb565_t;
  localparam rgb565_t RGB_BLACK   = 16'h0000;
  localparam rgb565_t RGB_WHITE   = 16'hFFFF;
  localparam rgb565_t RGB_RED     = 16'hF800;
  localparam rgb565_t RGB_GREEN   = 16'h07E0;
  localparam rgb565_t RGB_BLUE    = 16'h001F;
  localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
  localparam rgb565_t RGB_CYAN    = 16'h07FF;
  localparam rgb565_t RGB_MAGENTA = 16'hF81F;

  // Pack separate channel values into one RGB565 word
  function automatic rgb565_t rgb565(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vga_cnt.sv
// Wrapping 10-bit counter: advances when en is high, wraps MAX->0,
// and flags the terminal count so the next counter in the chain can step.
module vga_cnt
  import vga_pkg::*;
#(
  parameter logic [9:0] MAX = H_TOTAL - 10'd1
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       tc
);

  logic [9:0] cnt_reg;

  // Count up on enable, wrapping back to zero after MAX
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == MAX) ? 10'd0 : cnt_reg + 10'd1;
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == MAX);

endmodule

// File: rtl/vga_ctrl.sv
// VGA 640x480@60 Hz timing controller: H/V counters, sync decode, pixel request
// issued one clock ahead of the active window, and gating of returned pixel data.
// Optional feature macro: VGA_FRAME_CNT_EN adds frame_start / frame_cnt outputs.
module vga_ctrl
  import vga_pkg::*;
(
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
`endif
);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       tc_h;
  logic       tc_v;
  logic       v_win;
  logic       rgb_valid;
  logic       req;

  // Horizontal counter free-runs every pixel clock
  vga_cnt #(.MAX(H_TOTAL - 10'd1)) u_cnt_h (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (1'b1),
    .cnt     (cnt_h),
    .tc      (tc_h)
  );

  // Vertical counter steps on the last pixel of every line
  vga_cnt #(.MAX(V_TOTAL - 10'd1)) u_cnt_v (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (tc_h),
    .cnt     (cnt_v),
    .tc      (tc_v)
  );

  // Decode syncs, active window and the one-clock-early request window
  always_comb begin
    hsync     = (cnt_h <= H_SYNC - 10'd1);
    vsync     = (cnt_v <= V_SYNC - 10'd1);
    v_win     = (cnt_v >= VA) && (cnt_v < VA + V_VALID);
    rgb_valid = (cnt_h >= HA) && (cnt_h < HA + H_VALID) && v_win;
    req       = (cnt_h >= HA - 10'd1) && (cnt_h < HA + H_VALID - 10'd1) && v_win;
  end

  // Request coordinates lead the active window so registered pixel data lands aligned
  always_comb begin
    pix_x = PIX_IDLE;
    pix_y = PIX_IDLE;
    rgb   = RGB_BLACK;
    if (req) begin
      pix_x = cnt_h - (HA - 10'd1);
      pix_y = cnt_v - VA;
    end
    if (rgb_valid) begin
      rgb = pix_data;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic       started_reg;
  logic [7:0] frame_cnt_reg;

  // started_reg masks the (0,0) state seen straight out of reset; frame count bumps on the wrap
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      started_reg   <= 1'b0;
      frame_cnt_reg <= 8'd0;
    end else begin
      started_reg <= 1'b1;
      if (tc_h && tc_v) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  assign frame_start = started_reg && (cnt_h == 10'd0) && (cnt_v == 10'd0);
  assign frame_cnt   = frame_cnt_reg;
`else
  // Frame-wrap strobe only has a consumer when frame counting is built in
  logic frame_wrap_unused;
  assign frame_wrap_unused = tc_h & tc_v;
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed testbench for vga_ctrl. Pixel generator is emulated in tick():
// pix_data is updated from pix_x once per clock, i.e. one clock behind the request.
// Builds with or without VGA_FRAME_CNT_EN.
module tb_vga_ctrl;

  logic        vga_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] pix_data = 16'hABCD;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
`ifdef VGA_FRAME_CNT_EN
  logic        frame_start;
  logic [7:0]  frame_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int gen_mode = 0;  // 0: F800 while requested, 1: 16'h8000 | pix_x
  int h = 0;         // expected cnt_h at the current sampling point
  int v = 0;         // expected cnt_v at the current sampling point

  vga_ctrl dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
`endif
  );

  always #20 vga_clk = ~vga_clk;

  // Generator update for the current request, then advance one clock to the next negedge
  task automatic tick();
    if (pix_x == 10'h3FF) pix_data = 16'hABCD;
    else if (gen_mode == 0) pix_data = 16'hF800;
    else pix_data = {6'b100000, pix_x};
    @(negedge vga_clk);
    h = h + 1;
    if (h == 800) begin
      h = 0;
      v = v + 1;
      if (v == 525) v = 0;
    end
  endtask

  task automatic skip_to(input int th, input int tv);
    while (!(h == th && v == tv)) tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge vga_clk);
    rst_n = 1'b1;
    h = 0;
    v = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(negedge vga_clk);
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    tests++; if (vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    tests++; if (rgb !== 16'h0000) begin fails++; $display("FAIL reset_rgb: got %h want 0000", rgb); end
    tests++; if (pix_x !== 10'h3FF) begin fails++; $display("FAIL reset_pix_x: got %h want 3ff", pix_x); end
    tests++; if (pix_y !== 10'h3FF) begin fails++; $display("FAIL reset_pix_y: got %h want 3ff", pix_y); end
    rst_n = 1'b1;
    h = 0;
    v = 0;
    tick();
    tests++; if (dut.cnt_h !== 10'd1) begin fails++; $display("FAIL reset_release_cnt_h: got %0d want 1", dut.cnt_h); end
    $display("[TB] test_reset: 10-clk reset, outputs and first count checked");
  endtask

  task automatic test_line();
    int hs_cnt = 0;
    int red_cnt = 0;
    int bad = 0;
    int bad_h = -1;
    logic [15:0] exp_rgb;
    gen_mode = 0;
    skip_to(0, 35);
    for (int i = 0; i < 800; i++) begin
      if (hsync === 1'b1) hs_cnt++;
      exp_rgb = (h >= 144 && h <= 783) ? 16'hF800 : 16'h0000;
      if (rgb === 16'hF800) red_cnt++;
      if (rgb !== exp_rgb) begin bad++; if (bad_h < 0) bad_h = h; end
      if (h == 142) begin
        tests++; if (pix_x !== 10'h3FF) begin fails++; $display("FAIL pix_x_h142: got %h want 3ff", pix_x); end
      end
      if (h == 143) begin
        tests++; if (pix_x !== 10'd0) begin fails++; $display("FAIL pix_x_h143: got %0d want 0", pix_x); end
        tests++; if (pix_y !== 10'd0) begin fails++; $display("FAIL pix_y_line35: got %0d want 0", pix_y); end
      end
      if (h == 782) begin
        tests++; if (pix_x !== 10'd639) begin fails++; $display("FAIL pix_x_h782: got %0d want 639", pix_x); end
      end
      if (h == 783) begin
        tests++; if (pix_x !== 10'h3FF) begin fails++; $display("FAIL pix_x_h783: got %h want 3ff", pix_x); end
      end
      tick();
    end
    tests++; if (hs_cnt !== 96) begin fails++; $display("FAIL hsync_width: got %0d want 96", hs_cnt); end
    tests++; if (red_cnt !== 640) begin fails++; $display("FAIL rgb_active_count: got %0d want 640", red_cnt); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rgb_gating: %0d bad clks, first at h=%0d", bad, bad_h); end
    $display("[TB] test_line: line 35, hsync=%0d clks, rgb active=%0d clks", hs_cnt, red_cnt);
  endtask

  task automatic test_align();
    int bad = 0;
    int bad_h = -1;
    logic [15:0] exp_rgb;
    gen_mode = 1;
    skip_to(0, 36);
    for (int i = 0; i < 800; i++) begin
      exp_rgb = (h >= 144 && h <= 783) ? {6'b100000, 10'(h - 144)} : 16'h0000;
      if (rgb !== exp_rgb) begin bad++; if (bad_h < 0) bad_h = h; end
      if (h == 400) begin
        tests++; if (pix_y !== 10'd1) begin fails++; $display("FAIL pix_y_line36: got %0d want 1", pix_y); end
      end
      tick();
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rgb_alignment: %0d bad clks, first at h=%0d", bad, bad_h); end
    gen_mode = 0;
    $display("[TB] test_align: line 36, rgb carries column index with 1-clk latency");
  endtask

  task automatic test_vsync();
    int vs_cnt = 0;
    do_reset(3);
    for (int i = 0; i < 2400; i++) begin
      if (vsync === 1'b1) vs_cnt++;
      tick();
    end
    tests++; if (vs_cnt !== 1600) begin fails++; $display("FAIL vsync_width: got %0d want 1600", vs_cnt); end
    tests++; if (vsync !== 1'b0) begin fails++; $display("FAIL vsync_line3: got %b want 0", vsync); end
    $display("[TB] test_vsync: vsync high for %0d clks over lines 0..2", vs_cnt);
  endtask

  task automatic test_frame_end();
    do_reset(2);
    force dut.u_cnt_v.cnt_reg = 10'd513;
    #1;
    release dut.u_cnt_v.cnt_reg;
    v = 513;
    skip_to(143, 514);
    tests++; if (pix_y !== 10'd479) begin fails++; $display("FAIL pix_y_line514: got %0d want 479", pix_y); end
    skip_to(200, 514);
    tests++; if (rgb !== 16'hF800) begin fails++; $display("FAIL rgb_line514: got %h want f800", rgb); end
    skip_to(143, 515);
    tests++; if (pix_y !== 10'h3FF) begin fails++; $display("FAIL pix_y_line515: got %h want 3ff", pix_y); end
    skip_to(200, 515);
    tests++; if (rgb !== 16'h0000) begin fails++; $display("FAIL rgb_line515: got %h want 0000", rgb); end
    skip_to(799, 524);
    tests++; if (dut.cnt_h !== 10'd799 || dut.cnt_v !== 10'd524) begin
      fails++; $display("FAIL frame_last: got (%0d,%0d) want (799,524)", dut.cnt_h, dut.cnt_v); end
    tick();
    tests++; if (dut.cnt_h !== 10'd0 || dut.cnt_v !== 10'd0) begin
      fails++; $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", dut.cnt_h, dut.cnt_v); end
    tests++; if (hsync !== 1'b1 || vsync !== 1'b1) begin
      fails++; $display("FAIL frame_wrap_sync: got hs=%b vs=%b want 1 1", hsync, vsync); end
    $display("[TB] test_frame_end: rows 479/3ff at lines 514/515, wrap (799,524)->(0,0)");
  endtask

  task automatic test_mid_reset();
    force dut.u_cnt_v.cnt_reg = 10'd200;
    #1;
    release dut.u_cnt_v.cnt_reg;
    v = 200;
    skip_to(400, 200);
    tests++; if (pix_x !== 10'd257 || pix_y !== 10'd165) begin
      fails++; $display("FAIL mid_pix: got (%0d,%0d) want (257,165)", pix_x, pix_y); end
    tests++; if (rgb !== 16'hF800) begin fails++; $display("FAIL mid_rgb: got %h want f800", rgb); end
    rst_n = 1'b0;
    #1;
    tests++; if (hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 16'h0000 || pix_x !== 10'h3FF || pix_y !== 10'h3FF) begin
      fails++; $display("FAIL mid_reset_async: got hs=%b vs=%b rgb=%h x=%h y=%h", hsync, vsync, rgb, pix_x, pix_y); end
    @(negedge vga_clk);
    @(negedge vga_clk);
    rst_n = 1'b1;
    h = 0;
    v = 0;
    tick();
    tests++; if (dut.cnt_h !== 10'd1 || dut.cnt_v !== 10'd0) begin
      fails++; $display("FAIL mid_restart: got (%0d,%0d) want (1,0)", dut.cnt_h, dut.cnt_v); end
    skip_to(95, 0);
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL mid_hsync_h95: got %b want 1", hsync); end
    tick();
    tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL mid_hsync_h96: got %b want 0", hsync); end
    $display("[TB] test_mid_reset: reset at (400,200), restart from (0,0)");
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    do_reset(2);
    tests++; if (frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
      fails++; $display("FAIL fc_reset: got fs=%b cnt=%0d want 0 0", frame_start, frame_cnt); end
    tick();
    force dut.u_cnt_v.cnt_reg = 10'd524;
    #1;
    release dut.u_cnt_v.cnt_reg;
    v = 524;
    skip_to(0, 0);
    tests++; if (frame_start !== 1'b1 || frame_cnt !== 8'd1) begin
      fails++; $display("FAIL fc_first: got fs=%b cnt=%0d want 1 1", frame_start, frame_cnt); end
    tick();
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL fc_pulse_width: got %b want 0", frame_start); end
    force dut.frame_cnt_reg = 8'd255;
    force dut.u_cnt_v.cnt_reg = 10'd524;
    #1;
    release dut.frame_cnt_reg;
    release dut.u_cnt_v.cnt_reg;
    v = 524;
    skip_to(0, 0);
    tests++; if (frame_start !== 1'b1 || frame_cnt !== 8'd0) begin
      fails++; $display("FAIL fc_wrap: got fs=%b cnt=%0d want 1 0", frame_start, frame_cnt); end
    $display("[TB] test_frame_cnt: pulse at frame wrap, count 255->0");
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_align();
    test_vsync();
    test_frame_end();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
